// File: rtl/runner_pkg.sv
// Shared definitions for the runner game: action channel indices and helpers.
// Imported by action_input and action_debouncer.
package runner_pkg;

  localparam int ACT_JUMP    = 0;
  localparam int ACT_DUCK    = 1;
  localparam int NUM_ACTIONS = 2;

  typedef logic [NUM_ACTIONS-1:0] action_mask_t;

  // Width of a counter that must hold 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/action_debouncer.sv
// One action channel: synchronises both raw sources, selects one, debounces it
// into a stable level and flags the rising edge of that level.
module action_debouncer
  import runner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_in,
  input  logic button_in,
  input  logic use_sensor_s,
  input  logic clr,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sensor_sync;
  logic [SYNC_STAGES-1:0] button_sync;
  logic                   sync_bit;
  logic                   stable_d;
  logic [CNT_W-1:0]       cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: synchroniser flops are reset as well, so no pre-reset sample can leak into stable.
    if (rst) begin
      sensor_sync <= '0;
      button_sync <= '0;
    end else begin
      sensor_sync <= {sensor_sync[SYNC_STAGES-2:0], sensor_in};
      button_sync <= {button_sync[SYNC_STAGES-2:0], button_in};
    end
  end

  // Both sources are already synchronised, so switching between them is glitch-safe.
  assign sync_bit = use_sensor_s ? sensor_sync[SYNC_STAGES-1] : button_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (DEBOUNCE_CYCLES == 0) begin
        stable <= sync_bit;
        cnt    <= '0;
      end else if (clr || sync_bit == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_bit;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/action_input.sv
// Per-action input conditioner: debounced held levels, frame-latched press flags
// and saturating missed-press counters. Define ACTION_INPUT_STRETCH_EN to stretch held.
module action_input
  import runner_pkg::*;
#(
  parameter int NUM_CH          = NUM_ACTIONS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MISS_W          = 8,
  parameter int STRETCH_FRAMES  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        sensor_in,
  input  logic [NUM_CH-1:0]        button_in,
  input  logic                     use_sensor,
  input  logic                     frame_tick,
  output logic [NUM_CH-1:0]        held,
  output logic [NUM_CH-1:0]        press_pending,
  output logic [NUM_CH*MISS_W-1:0] missed_presses
);

`ifdef ACTION_INPUT_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif
  localparam int SCNT_W = cnt_width(STRETCH_FRAMES);

  logic [SYNC_STAGES-1:0] use_sync;
  logic                   use_sensor_s;
  logic                   use_sensor_d;
  logic                   clr;
  logic [NUM_CH-1:0]      stable;
  logic [NUM_CH-1:0]      rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      use_sync     <= '0;
      use_sensor_d <= 1'b0;
    end else begin
      use_sync     <= {use_sync[SYNC_STAGES-2:0], use_sensor};
      use_sensor_d <= use_sensor_s;
    end
  end

  assign use_sensor_s = use_sync[SYNC_STAGES-1];
  // A source switch restarts every debounce window; stable levels are kept.
  assign clr = use_sensor_s ^ use_sensor_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic              pend;
    logic [MISS_W-1:0] miss;

    action_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk         (clk),
      .rst         (rst),
      .sensor_in   (sensor_in[ch]),
      .button_in   (button_in[ch]),
      .use_sensor_s(use_sensor_s),
      .clr         (clr),
      .stable      (stable[ch]),
      .rise        (rise[ch])
    );

    // A rise outranks frame_tick; a rise on an unconsumed press is an overrun.
    always_ff @(posedge clk) begin
      if (rst) begin
        pend <= 1'b0;
        miss <= '0;
      end else if (rise[ch]) begin
        pend <= 1'b1;
        if (pend && !frame_tick && miss != '1) begin
          miss <= miss + MISS_W'(1);
        end
      end else if (frame_tick) begin
        pend <= 1'b0;
      end
    end

    assign press_pending[ch]                   = pend;
    assign missed_presses[ch*MISS_W +: MISS_W] = miss;

    if (STRETCH_EN && STRETCH_FRAMES > 0) begin : g_stretch
      logic [SCNT_W-1:0] scnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          scnt <= '0;
        end else if (rise[ch]) begin
          scnt <= SCNT_W'(STRETCH_FRAMES);
        end else if (frame_tick && scnt != '0) begin
          scnt <= scnt - SCNT_W'(1);
        end
      end

      assign held[ch] = stable[ch] | (scnt != '0);
    end else begin : g_plain
      assign held[ch] = stable[ch];
    end
  end

endmodule

// File: tb/tb_action_input.sv
// Directed bench for action_input: stimulus pushes timed expectations into a
// scoreboard queue, a negedge monitor compares them against the DUT outputs.
module tb_action_input;
  import runner_pkg::*;

  localparam int NUM_CH = 2;
  localparam int MISS_W = 8;
  localparam logic [15:0] M_JUMP = 16'(1) << ACT_JUMP;
  localparam logic [15:0] M_DUCK = 16'(1) << ACT_DUCK;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        sensor_in = '0;
  logic [NUM_CH-1:0]        button_in = '0;
  logic                     use_sensor = 1'b0;
  logic                     frame_tick = 1'b0;
  logic [NUM_CH-1:0]        held;
  logic [NUM_CH-1:0]        press_pending;
  logic [NUM_CH*MISS_W-1:0] missed_presses;

  action_input #(
    .NUM_CH         (NUM_CH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .MISS_W         (MISS_W),
    .STRETCH_FRAMES (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor_in     (sensor_in),
    .button_in     (button_in),
    .use_sensor    (use_sensor),
    .frame_tick    (frame_tick),
    .held          (held),
    .press_pending (press_pending),
    .missed_presses(missed_presses)
  );

  always #5 clk = ~clk;

  typedef enum int {K_HELD, K_PEND, K_MISS0, K_MISS1} kind_e;
  typedef struct packed {
    int          cyc;
    kind_e       kind;
    logic [15:0] mask;
    logic [15:0] exp;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input kind_e k, input logic [15:0] mask,
                           input logic [15:0] v, input int tag);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = k;
    e.mask = mask;
    e.exp  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input kind_e k);
    case (k)
      K_HELD:  return 16'(held);
      K_PEND:  return 16'(press_pending);
      K_MISS0: return 16'(missed_presses[MISS_W-1:0]);
      default: return 16'(missed_presses[2*MISS_W-1:MISS_W]);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [15:0] act;
        act = observe(sb[i].kind) & sb[i].mask;
        n_cmp++;
        if (sb[i].cyc < cyc || act !== (sb[i].exp & sb[i].mask)) begin
          n_bad++;
          $display("FAIL %s tag=%0d cycle=%0d: got 0x%0h, want 0x%0h",
                   sb[i].kind.name(), sb[i].tag, cyc, act, sb[i].exp & sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int exp_miss;

    // Reset held for three edges, then idle.
    step(1);
    for (int d = 0; d < 3; d++) begin
      expect_at(d, K_HELD, 16'h3, 16'h0, 1);
      expect_at(d, K_PEND, 16'h3, 16'h0, 2);
      expect_at(d, K_MISS0, 16'hff, 16'h0, 3);
      expect_at(d, K_MISS1, 16'hff, 16'h0, 4);
    end
    step(2);
    rst = 1'b0;
    for (int d = 0; d < 6; d++) begin
      expect_at(d, K_HELD, 16'h3, 16'h0, 5);
      expect_at(d, K_PEND, 16'h3, 16'h0, 6);
      expect_at(d, K_MISS0, 16'hff, 16'h0, 7);
    end
    step(6);

    // Clean press on jump: held after 6 cycles, pending one later.
    button_in[ACT_JUMP] = 1'b1;
    expect_at(5, K_HELD, M_JUMP, 16'h0, 10);
    expect_at(6, K_HELD, M_JUMP, M_JUMP, 11);
    expect_at(6, K_PEND, M_JUMP, 16'h0, 12);
    expect_at(7, K_PEND, M_JUMP, M_JUMP, 13);
    step(10);
    frame_tick = 1'b1;
    expect_at(0, K_PEND, M_JUMP, M_JUMP, 14);
    expect_at(1, K_PEND, M_JUMP, 16'h0, 15);
    for (int d = 1; d < 6; d++) expect_at(d, K_HELD, M_JUMP, M_JUMP, 16);
    step(1);
    frame_tick = 1'b0;
    step(9);
    button_in[ACT_JUMP] = 1'b0;
    expect_at(5, K_HELD, M_JUMP, M_JUMP, 17);
    expect_at(6, K_HELD, M_JUMP, 16'h0, 18);
    expect_at(8, K_PEND, M_JUMP, 16'h0, 19);
    step(10);

    // Three-cycle glitch on duck never reaches held or pending.
    for (int d = 0; d < 13; d++) begin
      expect_at(d, K_HELD, M_DUCK, 16'h0, 30);
      expect_at(d, K_PEND, M_DUCK, 16'h0, 31);
    end
    button_in[ACT_DUCK] = 1'b1;
    step(3);
    button_in[ACT_DUCK] = 1'b0;
    step(12);

    // Rise coinciding with frame_tick keeps the press pending.
    button_in[ACT_JUMP] = 1'b1;
    expect_at(6, K_HELD, M_JUMP, M_JUMP, 40);
    expect_at(6, K_PEND, M_JUMP, 16'h0, 41);
    step(6);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    expect_at(0, K_PEND, M_JUMP, M_JUMP, 42);
    expect_at(0, K_MISS0, 16'hff, 16'h0, 43);
    step(3);
    button_in[ACT_JUMP] = 1'b0;
    step(10);

    // Unconsumed presses count as missed, saturating at 255.
    exp_miss = 0;
    for (int k = 0; k < 303; k++) begin
      button_in[ACT_JUMP] = 1'b1;
      step(10);
      button_in[ACT_JUMP] = 1'b0;
      step(10);
      exp_miss = (exp_miss < 255) ? exp_miss + 1 : 255;
      expect_at(0, K_MISS0, 16'hff, 16'(exp_miss), (k < 3) ? 50 : 51);
      expect_at(0, K_PEND, M_JUMP, M_JUMP, 52);
    end
    expect_at(0, K_MISS1, 16'hff, 16'h0, 53);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    expect_at(0, K_PEND, M_JUMP, 16'h0, 54);
    expect_at(0, K_MISS0, 16'hff, 16'hff, 55);
    step(5);

    // Source switch drops held without a spurious press.
    button_in[ACT_JUMP] = 1'b1;
    step(10);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(5);
    use_sensor = 1'b1;
    for (int d = 0; d < 7; d++) expect_at(d, K_HELD, M_JUMP, M_JUMP, 60);
    expect_at(8, K_HELD, M_JUMP, 16'h0, 61);
    expect_at(9, K_HELD, M_JUMP, 16'h0, 62);
    for (int d = 0; d < 13; d++) expect_at(d, K_PEND, M_JUMP, 16'h0, 63);
    step(15);

    // Short sensor duck, followed by three frame ticks.
    sensor_in[ACT_DUCK] = 1'b1;
    expect_at(6, K_HELD, M_DUCK, M_DUCK, 70);
    expect_at(13, K_HELD, M_DUCK, M_DUCK, 71);
    expect_at(7, K_PEND, M_DUCK, M_DUCK, 72);
    expect_at(21, K_PEND, M_DUCK, 16'h0, 73);
`ifdef ACTION_INPUT_STRETCH_EN
    expect_at(15, K_HELD, M_DUCK, M_DUCK, 74);
    expect_at(21, K_HELD, M_DUCK, M_DUCK, 75);
    expect_at(31, K_HELD, M_DUCK, M_DUCK, 76);
    expect_at(40, K_HELD, M_DUCK, M_DUCK, 77);
    expect_at(41, K_HELD, M_DUCK, 16'h0, 78);
    expect_at(45, K_HELD, M_DUCK, 16'h0, 79);
`else
    expect_at(14, K_HELD, M_DUCK, 16'h0, 74);
    expect_at(15, K_HELD, M_DUCK, 16'h0, 75);
    expect_at(21, K_HELD, M_DUCK, 16'h0, 76);
    expect_at(41, K_HELD, M_DUCK, 16'h0, 77);
`endif
    step(8);
    sensor_in[ACT_DUCK] = 1'b0;
    step(12);
    for (int t = 0; t < 3; t++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(9);
    end
    step(5);

    // Reset is the only thing that clears the missed-press counter.
    rst = 1'b1;
    expect_at(1, K_MISS0, 16'hff, 16'h0, 80);
    expect_at(1, K_HELD, 16'h3, 16'h0, 81);
    expect_at(1, K_PEND, 16'h3, 16'h0, 82);
    step(1);
    rst = 1'b0;
    step(3);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/action_input.md
Name: action_input

Overview:
- Per-action input conditioner between raw player inputs and `runner`. Generalised successor to the single-bit jump/duck path.
- Handles N channels, each selectable between sensor and button source. Each channel gets a synchroniser, a debounce filter, and a frame-latched press flag.
- Frame-latched press flags are consumed once per game frame, so no press is lost between game ticks. Saturating missed-press counters expose overruns.
- Sits in the 33 MHz domain: `clk` is `clk_33m`, `rst` is `reset_33m`. Outputs feed the `runner` `jumping`/`ducking` inputs.

Parameters:
- NUM_CH, 2, number of action channels (index from runner_pkg: ACT_JUMP=0, ACT_DUCK=1).
- SYNC_STAGES, 2, synchroniser flops per input (≥2).
- DEBOUNCE_CYCLES, 4, consecutive differing cycles before the stable state flips; 0 bypasses debounce.
- MISS_W, 8, width of each saturating missed-press counter.
- STRETCH_FRAMES, 3, minimum held length in frame ticks (used only with the optional feature).

Ports:
- clk, in, 1, 33 MHz system clock.
- rst, in, 1, synchronous reset, active-high.
- sensor_in, in, NUM_CH, raw motion-detector levels; asynchronous to clk.
- button_in, in, NUM_CH, raw button levels, active-high (caller inverts touch_btn); asynchronous.
- use_sensor, in, 1, source select (dip switch); asynchronous.
- frame_tick, in, 1, one-cycle pulse per game frame (painter finished); consumes pending presses.
- held, out, NUM_CH, debounced (optionally stretched) level per channel.
- press_pending, out, NUM_CH, sticky "rising edge since last frame_tick".
- missed_presses, out, NUM_CH*MISS_W, per-channel saturating count of presses lost while already pending; channel i occupies bits [i*MISS_W +: MISS_W].

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge):
  - All synchroniser flops, stable states, debounce counters, press_pending, missed_presses and stretch counters go to 0.
  - held=0 and press_pending=0 from the next cycle.
  - Reset mid-debounce discards the partial count.
- Source select:
  - use_sensor passes through its own SYNC_STAGES synchroniser.
  - raw[i] = use_sensor_s ? sensor_in[i] : button_in[i]. The mux sits after the synchronisers; both sources are synchronised.
  - When use_sensor_s toggles, all debounce counters clear that cycle. Stable states are retained.
- Debounce, per channel:
  - If sync[i] == stable[i]: cnt=0.
  - Otherwise cnt increments. When cnt reaches DEBOUNCE_CYCLES-1 while still differing, stable[i] <= sync[i] and cnt <= 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES=0: stable[i] <= sync[i] every cycle.
- Latency, input change to held change: SYNC_STAGES + DEBOUNCE_CYCLES cycles (+1 when DEBOUNCE_CYCLES=0). Defaults give 6 cycles.
- Glitches shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never reach stable.
- Edge and pending:
  - rise[i] = stable[i] & ~stable_d[i].
  - Priority: rise beats frame_tick. On a simultaneous rise and frame_tick, pending stays 1.
  - frame_tick alone clears pending.
  - rise with pending already 1 and no frame_tick: pending stays 1 and missed_presses[i] increments, saturating at 2^MISS_W-1.
  - missed_presses clears only on reset.
- held[i] = stable[i], registered (no extra cycle beyond the latency above).

Optional Feature:
- Macro: ACTION_INPUT_STRETCH_EN.
- When defined:
  - Each channel has a frame counter (width $clog2(STRETCH_FRAMES+1)), loaded with STRETCH_FRAMES on rise[i].
  - The counter decrements on each frame_tick while nonzero.
  - held[i] = stable[i] | (scnt[i] != 0).
  - A new rise while counting reloads the counter.
  - Purpose: short sensor ducks last a visible number of frames.
- When undefined: held[i] = stable[i]; no stretch counters exist; STRETCH_FRAMES is ignored.

Decomposition:
- runner_pkg gains ACT_JUMP, ACT_DUCK, NUM_ACTIONS, and typedef action_mask_t (logic [NUM_ACTIONS-1:0]).
- One natural sub-module, action_debouncer: one channel's synchroniser, debounce counter and stable/edge outputs. Parameterised by SYNC_STAGES and DEBOUNCE_CYCLES; generated NUM_CH times.
- Pending logic, miss counters and the stretch option stay in action_input.

Test Plan (NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MISS_W=8, STRETCH_FRAMES=3):
- Reset then idle: rst high 3 cycles -> held=00, press_pending=00, missed_presses=0 throughout.
- Clean press: use_sensor=0, button_in[0] 0→1 and held 20 cycles -> held[0] rises exactly 6 cycles after the change; press_pending[0]=1 the following cycle; frame_tick pulse -> press_pending[0]=0 next cycle; held[0] stays 1.
- Glitch rejection: button_in[1] high for 3 cycles then low -> held[1] and press_pending[1] never assert.
- Tick/edge collision and overrun: rise on ch0 coincides with frame_tick -> pending stays 1. Then three more press/release cycles (each 10 cycles high, 10 low) without frame_tick -> missed_presses[0]=3. 300 such presses -> saturates at 255.
- Source switch: button_in[0]=1, sensor_in[0]=0, toggle use_sensor to 1 -> held[0] falls 2+2+4 cycles after the use_sensor change, with no spurious press_pending.
- With ACTION_INPUT_STRETCH_EN: sensor_in[1] pulse long enough to debounce, released after 2 cycles stable -> held[1] stays 1 until the 3rd frame_tick after the rise, then 0. Without the macro -> held[1] drops as soon as stable[1] drops.
